adc_sample_scheduler: RTL

- Sequences the per-ADC SPI_MASTER_DEVICE instances on the ADC board.
- Generates the sample-rate tick and round-robins a conversion sweep over the enabled ADCs, driving each one's ENA and command word.
- Captures each result on FIN, tags it with the ADC index and pushes it into the 16-bit sample FIFO, with full-FIFO drop accounting.
- Replaces the free-running ENA gating in the top level.

---
 rtl/adc_pkg.sv | 32 +++
 rtl/sample_tick_gen.sv | 39 +++
 rtl/adc_sample_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared types and constants for the ADC sample scheduler.
//   state_t    : sweep FSM state encoding
//   CMD_PREFIX : fixed upper nibble of the SPI command word
//   CMD_RANGE  : fixed low 7-bit range field of the SPI command word
//   TAG_W      : width of the ADC index carried alongside each sample
//   DATA_W     : sample / command word width
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [3:0] CMD_PREFIX = 4'b0001;
  localparam logic [6:0] CMD_RANGE  = 7'b1000000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    CONV,
    PUSH,
    NEXT
  } state_t;

  // Command word sent to every ADC of a sweep: {prefix, 1, 00, channel, range}
  function automatic logic [DATA_W-1:0] make_cmd(input logic [1:0] ch);
    return {CMD_PREFIX, 1'b1, 2'b00, ch, CMD_RANGE};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
// Free-running sample-period counter. Counts 0..CLK_DIV-1 while enabled and
// is held at 0 while disabled; tick_o is high for the single cycle in which
// the count sits at CLK_DIV-1.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   en_i   : run enable
//   tick_o : one-cycle sample-rate tick
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int CLK_DIV = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gated with en_i so a disabled counter never produces a tick.
  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_scheduler.sv
// ---------------------------------------------------------------------------
// adc_sample_scheduler
// On every sample tick, sweeps the enabled ADC SPI masters in ascending index
// order: raises one ENA at a time, waits for that master's FIN (or a timeout),
// then writes the captured result plus its ADC index into the sample FIFO.
// Ports:
//   SYS_CLK     : system clock
//   reset       : asynchronous active-low reset
//   EN          : run enable
//   ADC_MASK    : per-ADC enable, sampled at the start of each sweep
//   CH_SEL      : ADC input channel, sampled at the start of each sweep
//   SPI_ENA     : one-hot enable to the SPI masters
//   SPI_CMD     : command word for the current sweep
//   SPI_FIN     : per-master one-cycle done pulse
//   SPI_DATA    : per-master result, 16 bits each, valid with FIN
//   FIFO_FULL   : sample FIFO full
//   FIFO_WR     : one-cycle FIFO write strobe
//   FIFO_DIN    : sample data
//   FIFO_TAG    : ADC index of FIFO_DIN
//   BUSY        : sweep in progress
//   OVERRUN_CNT : samples dropped on a full FIFO, saturating
//   MISSED_TICK : sticky, a tick arrived during a sweep
//   TIMEOUT_ERR : sticky per-ADC FIN timeout flags
// ---------------------------------------------------------------------------
module adc_sample_scheduler
  import adc_pkg::*;
#(
  parameter int N_ADC   = 5,
  parameter int CLK_DIV = 256,
  parameter int TIMEOUT = 64
) (
  input  logic                    SYS_CLK,
  input  logic                    reset,
  input  logic                    EN,
  input  logic [N_ADC-1:0]        ADC_MASK,
  input  logic [1:0]              CH_SEL,
  output logic [N_ADC-1:0]        SPI_ENA,
  output logic [DATA_W-1:0]       SPI_CMD,
  input  logic [N_ADC-1:0]        SPI_FIN,
  input  logic [DATA_W*N_ADC-1:0] SPI_DATA,
  input  logic                    FIFO_FULL,
  output logic                    FIFO_WR,
  output logic [DATA_W-1:0]       FIFO_DIN,
  output logic [TAG_W-1:0]        FIFO_TAG,
  output logic                    BUSY,
  output logic [15:0]             OVERRUN_CNT,
  output logic                    MISSED_TICK,
  output logic [N_ADC-1:0]        TIMEOUT_ERR
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t              state_q;
  logic [TAG_W-1:0]    idx_q;
  logic [N_ADC-1:0]    mask_q;
  logic [N_ADC-1:0]    ena_q;
  logic [DATA_W-1:0]   cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic [TW-1:0]       tmo_q;
  logic                busy_q;
  logic [15:0]         ovr_q;
  logic                missed_q;
  logic [N_ADC-1:0]    tmo_err_q;

  logic                tick;
  logic [TAG_W-1:0]    first_idx;
  logic [TAG_W-1:0]    nxt_idx;
  logic                nxt_vld;
  logic [N_ADC-1:0]    ena_onehot;
  logic [DATA_W-1:0]   data_arr [N_ADC];

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (SYS_CLK),
    .rst_ni (reset),
    .en_i   (EN),
    .tick_o (tick)
  );

  for (genvar gi = 0; gi < N_ADC; gi++) begin : g_data
    assign data_arr[gi] = SPI_DATA[gi*DATA_W +: DATA_W];
  end

  // Lowest set bit of the live mask (sweep start) and next higher set bit of
  // the latched mask above the current index (sweep advance). Scanning from
  // the top down leaves the lowest qualifying index in the result.
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    nxt_vld   = 1'b0;
    for (int i = N_ADC - 1; i >= 0; i--) begin
      if (ADC_MASK[i]) begin
        first_idx = TAG_W'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        nxt_vld = 1'b1;
        nxt_idx = TAG_W'(i);
      end
    end
  end

  always_comb begin
    ena_onehot        = '0;
    ena_onehot[idx_q] = 1'b1;
  end

  always_ff @(posedge SYS_CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      ena_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      ovr_q     <= '0;
      missed_q  <= 1'b0;
      tmo_err_q <= '0;
    end else begin
      // Ticks during a sweep are only recorded, never queued.
      if (tick && busy_q) begin
        missed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (EN) begin
            state_q <= WAIT_TICK;
          end
        end

        WAIT_TICK: begin
          if (!EN) begin
            state_q <= IDLE;
          end else if (tick && (ADC_MASK != '0)) begin
            mask_q  <= ADC_MASK;
            cmd_q   <= make_cmd(CH_SEL);
            idx_q   <= first_idx;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end

        START: begin
          ena_q   <= ena_onehot;
          tmo_q   <= '0;
          state_q <= CONV;
        end

        CONV: begin
          // Only the FIN of the addressed master is honoured.
          if (SPI_FIN[idx_q]) begin
            data_q  <= data_arr[idx_q];
            ena_q   <= '0;
            state_q <= PUSH;
          end else if (tmo_q == TMO_LAST) begin
            ena_q            <= '0;
            tmo_err_q[idx_q] <= 1'b1;
            state_q          <= NEXT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        PUSH: begin
          if (FIFO_FULL && (ovr_q != 16'hFFFF)) begin
            ovr_q <= ovr_q + 16'd1;
          end
          state_q <= NEXT;
        end

        NEXT: begin
          // EN low ends the sweep after the conversion just finished.
          if (EN && nxt_vld) begin
            idx_q   <= nxt_idx;
            state_q <= START;
          end else begin
            busy_q  <= 1'b0;
            state_q <= EN ? WAIT_TICK : IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // The write decision uses FIFO_FULL of the PUSH cycle itself, so the strobe
  // is gated combinationally rather than registered a cycle early.
  assign FIFO_WR     = (state_q == PUSH) && !FIFO_FULL;
  assign FIFO_DIN    = data_q;
  assign FIFO_TAG    = idx_q;
  assign SPI_ENA     = ena_q;
  assign SPI_CMD     = cmd_q;
  assign BUSY        = busy_q;
  assign OVERRUN_CNT = ovr_q;
  assign MISSED_TICK = missed_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule
